// File: rtl/mux_gadget_pkg.sv
// Shared definitions for the glitch-free 2:1 gadget mux and its control sequencer.
package mux_gadget_pkg;

    // Source encodings carried on req_src and cur_src
    localparam logic [1:0] SRC_PARK = 2'd0;
    localparam logic [1:0] SRC_FF   = 2'd1;
    localparam logic [1:0] SRC_TT   = 2'd2;
    localparam logic [1:0] SRC_XX   = 2'd3;

    // Sequencer states; encodings kept fixed so older tooling and dumps stay comparable
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PARK    = 3'd1,
        ST_STEP_A1 = 3'd2,
        ST_STEP_A2 = 3'd3,
        ST_ENGAGE  = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

    // Final {dataA_2, dataA_1, sel} for a source. For XX the dataA_1 bit is a
    // don't-care (masked by dataA_2) and for PARK only sel matters; callers
    // must treat those bits accordingly.
    function automatic logic [2:0] src_to_ctrl(input logic [1:0] src);
        logic [2:0] ctrl;
        case (src)
            SRC_PARK: ctrl = 3'b000;
            SRC_FF:   ctrl = 3'b001;
            SRC_TT:   ctrl = 3'b011;
            SRC_XX:   ctrl = 3'b101;
            default:  ctrl = 3'b000;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Load-and-count-down hold timer. zero marks an idle timer; expire marks the
// edge on which the count reaches zero, so a hold of N cycles ends N edges
// after the load edge.
module settle_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load has priority, otherwise decrement and stick at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero   = (cnt_r == {CNT_W{1'b0}});
    assign expire = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/glitchless_mux_sel_sequencer.sv
// Break-before-make sequencer for the gadget mux control lines. Moves
// {dataA_2, dataA_1, sel} one bit per edge, with sel low whenever a dataA
// bit moves, and holds each change for SETTLE_CYCLES before the next.
module glitchless_mux_sel_sequencer
    import mux_gadget_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_src,
    output logic       req_ready,
    output logic       sel,
    output logic       dataA_2,
    output logic       dataA_1,
    output logic       busy,
    output logic       done,
    output logic [1:0] cur_src
);

    seq_state_e state_r;
    seq_state_e step_s;
    logic [1:0] tgt_r;
    logic [1:0] cur_src_r;
    logic       sel_r;
    logic       data_a2_r;
    logic       data_a1_r;
    logic       busy_r;
    logic       done_r;
    logic [2:0] tgt_ctrl_s;
    logic       need_a1_s;
    logic       need_a2_s;
    logic       active_s;
    logic       go_s;
    logic       tmr_load_s;
    logic       tmr_zero_s;
    logic       tmr_expire_s;

    // Choose the single next control change (or completion) from the current lines and target
    always_comb begin
        tgt_ctrl_s = src_to_ctrl(tgt_r);
        // dataA_1 only matters for FF/TT; it is masked whenever dataA_2 is high
        need_a1_s  = tgt_ctrl_s[0] && !tgt_ctrl_s[2] && (data_a1_r != tgt_ctrl_s[1]);
        need_a2_s  = tgt_ctrl_s[0] && (data_a2_r != tgt_ctrl_s[2]);
        if (sel_r && (!tgt_ctrl_s[0] || need_a1_s || need_a2_s)) begin
            step_s = ST_PARK;
        end else if (need_a1_s) begin
            step_s = ST_STEP_A1;
        end else if (need_a2_s) begin
            step_s = ST_STEP_A2;
        end else if (tgt_ctrl_s[0] && !sel_r) begin
            step_s = ST_ENGAGE;
        end else begin
            step_s = ST_DONE;
        end
    end

    // Advance when a hold expires, or immediately on entry from IDLE (timer already idle)
    always_comb begin
        active_s   = (state_r == ST_PARK) || (state_r == ST_STEP_A1) ||
                     (state_r == ST_STEP_A2) || (state_r == ST_ENGAGE);
        go_s       = active_s && (tmr_zero_s || tmr_expire_s);
        tmr_load_s = go_s && (step_s != ST_DONE);
    end

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (CNT_W'(SETTLE_CYCLES)),
        .zero     (tmr_zero_s),
        .expire   (tmr_expire_s)
    );

    // Sequencer state, control lines and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tgt_r     <= SRC_PARK;
            cur_src_r <= SRC_PARK;
            sel_r     <= 1'b0;
            data_a2_r <= 1'b0;
            data_a1_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        tgt_r   <= req_src;
                        busy_r  <= 1'b1;
                        state_r <= ST_PARK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PARK, ST_STEP_A1, ST_STEP_A2, ST_ENGAGE: begin
                    if (go_s) begin
                        state_r <= step_s;
                        case (step_s)
                            ST_PARK:    sel_r     <= 1'b0;
                            ST_STEP_A1: data_a1_r <= ~data_a1_r;
                            ST_STEP_A2: data_a2_r <= ~data_a2_r;
                            ST_ENGAGE:  sel_r     <= 1'b1;
                            ST_DONE: begin
                                done_r    <= 1'b1;
                                busy_r    <= 1'b0;
                                cur_src_r <= tgt_r;
                            end
                            default:    state_r   <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign sel       = sel_r;
    assign dataA_2   = data_a2_r;
    assign dataA_1   = data_a1_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cur_src   = cur_src_r;

endmodule
